// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction-memory line port, redirect input and decode handshake.
// fsmState exposes the fetch FSM state for observation.
interface fetch_if;
  logic [31:0]  imemAddr;
  logic [127:0] imemQdata;
  logic         imemReady;
  logic         redirect;
  logic [31:0]  redirectPc;
  logic         instValid;
  logic         instReady;
  logic [31:0]  inst;
  logic [31:0]  instPc;
  logic [1:0]   fsmState;

  // Decode handshake: an instruction moves when instValid & instReady are both high
  // at a rising edge; while instValid is high and instReady low, inst/instPc hold.
  modport master (
    output imemAddr, instValid, inst, instPc, fsmState,
    input  imemQdata, imemReady, redirect, redirectPc, instReady
  );
  modport slave (
    input  imemAddr, instValid, inst, instPc, fsmState,
    output imemQdata, imemReady, redirect, redirectPc, instReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Line-buffered instruction fetch: requests a 16-byte line, then hands its words to decode
// one per transfer; redirects that land in the buffered line skip the memory round trip.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic      clk,
  input logic      resetN,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {REQ = 2'd0, WAIT = 2'd1, HAVE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    addr_q, addr_d;
  logic [127:0]   line_q, line_d;
  logic [27:0]    tag_q, tag_d;

  logic [31:0]    pc_inc;
  logic [31:0]    tgt;
  logic [31:0]    word;
  logic           xfer;
  logic           hit;
  logic           unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirectPc[1:0];

  always_comb begin
    pc_inc = pc_q + 32'd4;
    tgt    = {bus.redirectPc[31:2], 2'b00};
    xfer   = (state_q == HAVE) && bus.instReady;
    hit    = (state_q == HAVE) && (tgt[31:4] == tag_q);
    case (pc_q[3:2])
      2'd0:    word = line_q[127:96];
      2'd1:    word = line_q[95:64];
      2'd2:    word = line_q[63:32];
      default: word = line_q[31:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    line_d  = line_q;
    tag_d   = tag_q;
    if (bus.redirect) begin
      // Redirect overrides everything; an instruction transferred this cycle is still consumed.
      pc_d = tgt;
      if (!hit) begin
        addr_d  = {tgt[31:4], 4'b0000};
        state_d = REQ;
      end
    end else begin
      case (state_q)
        REQ: state_d = WAIT;
        WAIT: begin
          if (bus.imemReady) begin
            line_d  = bus.imemQdata;
            tag_d   = pc_q[31:4];
            state_d = HAVE;
          end
        end
        HAVE: begin
          if (xfer) begin
            pc_d = pc_inc;
            if (pc_q[3:2] == 2'd3) begin
              addr_d  = {pc_inc[31:4], 4'b0000};
              state_d = REQ;
            end
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      addr_q  <= {RESET_PC[31:4], 4'b0000};
      line_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.imemAddr  = addr_q;
  assign bus.instValid = (state_q == HAVE);
  assign bus.inst      = (state_q == HAVE) ? word : 32'd0;
  assign bus.instPc    = (state_q == HAVE) ? pc_q : 32'd0;
  assign bus.fsmState  = state_q;

endmodule
